// File: rtl/arty_s7_pkg.sv
// Shared types and elaboration helpers for the Arty S7 board-test controller.
// Latency: none, types and constant functions only.
// Backpressure: not applicable.
package arty_s7_pkg;

  typedef enum logic [1:0] {
    MODE_SW      = 2'd0,
    MODE_COUNT   = 2'd1,
    MODE_BREATHE = 2'd2
  } mode_t;

  // Ceiling log2. Used to size counters, so clog2(1) is 0 and clog2(2) is 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Debounce stable time in clock cycles. Never less than one cycle.
  function automatic int db_cycles(input int clk_freq, input int ms);
    int c;
    c = (clk_freq / 1000) * ms;
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/arty_s7_rgb_ctrl_if.sv
// Board-side I/O bundle: switches and buttons in, plain/RGB LEDs and mode out.
// Latency: none, wiring only.
// Backpressure: none, all signals are level or PWM waveforms.
interface arty_s7_rgb_ctrl_if #(
  parameter int NUM_LED = 4,
  parameter int NUM_RGB = 2
);
  logic [NUM_LED-1:0] sw;
  logic [3:0]         btn;
  logic [NUM_LED-1:0] led;
  logic [NUM_RGB-1:0] led_r;
  logic [NUM_RGB-1:0] led_g;
  logic [NUM_RGB-1:0] led_b;
  logic [1:0]         mode;

  // Board side: drives the pins, watches the LEDs.
  modport master (output sw, btn, input led, led_r, led_g, led_b, mode);
  // Controller side.
  modport slave  (input sw, btn, output led, led_r, led_g, led_b, mode);
endinterface

// File: rtl/arty_s7_debounce.sv
// One-button debouncer: 2-flop sync, stable counter, debounced level, press pulse.
// Latency: press fires 2 + DB_CYC cycles after a clean rising edge on the pin.
// Backpressure: none, the press pulse is a single cycle and is never held.
module arty_s7_debounce
  import arty_s7_pkg::*;
#(
  parameter int DB_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = clog2(DB_CYC + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the debounced level; flip on the last one.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DB_CYC - 1)) begin
      cnt_d   = '0;
      level_d = sync2_q;
      press_d = sync2_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Synchroniser and debounce state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/arty_s7_rgb_ctrl.sv
// Board-test controller: button-driven mode FSM, LED source mux, per-channel PWM RGB brightness.
// Latency: sw pin to led 3 cycles; duty to PWM pin 1 cycle (2 with ARTY_S7_PWM_GAMMA_EN).
// Backpressure: none, free-running outputs; ARTY_S7_PWM_GAMMA_EN selects squared duty.
module arty_s7_rgb_ctrl
  import arty_s7_pkg::*;
#(
  parameter int CLK_FREQ    = 12000000,
  parameter int NUM_LED     = 4,
  parameter int NUM_RGB     = 2,
  parameter int PWM_BITS    = 8,
  parameter int DEBOUNCE_MS = 10,
  parameter int STEP_HZ     = 4
) (
  input logic              clk,
  input logic              rst,
  arty_s7_rgb_ctrl_if.slave io
);

  localparam int DB_CYC   = db_cycles(CLK_FREQ, DEBOUNCE_MS);
  localparam int TICK_RAW = CLK_FREQ / STEP_HZ;
  localparam int TICK_CYC = (TICK_RAW < 1) ? 1 : TICK_RAW;
  localparam int BR_RAW   = CLK_FREQ / (STEP_HZ * (1 << PWM_BITS));
  localparam int BR_CYC   = (BR_RAW < 1) ? 1 : BR_RAW;
  localparam int TW       = clog2(TICK_CYC + 1);
  localparam int BW       = clog2(BR_CYC + 1);
  localparam int SELW     = (NUM_RGB > 1) ? clog2(NUM_RGB) : 1;
  localparam int PW       = 2 * PWM_BITS + 1;
  localparam logic [PWM_BITS-1:0] BRI_RST  = PWM_BITS'(1 << (PWM_BITS - 2));
  localparam logic [PWM_BITS-1:0] BRI_STEP = PWM_BITS'(1 << (PWM_BITS - 3));
  localparam logic [PWM_BITS-1:0] BRI_MAX  = '1;

  logic [3:0]          press;
  mode_t               mode_q;
  logic                in_count, in_breathe, enter_count, tick, br_tick;
  logic [NUM_LED-1:0]  sw_s1_q, sw_s2_q;
  logic [NUM_LED-1:0]  led_q, led_d, cnt_q, cnt_d;
  logic [SELW-1:0]     sel_q, sel_d;
  logic [PWM_BITS-1:0] bri_q [NUM_RGB];
  logic [PWM_BITS-1:0] bri_d [NUM_RGB];
  logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]       br_cnt_q, br_cnt_d;
  logic [PWM_BITS:0]   phase_q, phase_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d, lvl;
  logic [PWM_BITS-1:0] duty_lin [NUM_RGB];
  logic [PWM_BITS-1:0] duty [NUM_RGB];
  logic [PW-1:0]       prod;
  logic [NUM_RGB-1:0]  r_q, r_d, g_q, g_d, b_q, b_d;

  for (genvar i = 0; i < 4; i++) begin : g_db
    arty_s7_debounce #(.DB_CYC(DB_CYC)) u_db (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (io.btn[i]),
      .press_o (press[i])
    );
  end

  // Mode FSM: btn[0] press steps SW -> COUNT -> BREATHE -> SW; stray code 3 behaves as SW.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_SW;
    end else if (press[0]) begin
      case (mode_q)
        MODE_COUNT:   mode_q <= MODE_BREATHE;
        MODE_BREATHE: mode_q <= MODE_SW;
        default:      mode_q <= MODE_COUNT;
      endcase
    end
  end

  assign in_count    = (mode_q == MODE_COUNT);
  assign in_breathe  = (mode_q == MODE_BREATHE);
  assign enter_count = press[0] && !in_count && !in_breathe;
  assign tick        = (tick_cnt_q == TW'(TICK_CYC - 1));
  assign br_tick     = (br_cnt_q == BW'(BR_CYC - 1));

  // Next state of counters, selection and brightness.
  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    br_cnt_d   = br_tick ? '0 : br_cnt_q + BW'(1);
    phase_d    = br_tick ? phase_q + (PWM_BITS+1)'(1) : phase_q;
    pwm_cnt_d  = pwm_cnt_q + PWM_BITS'(1);
    cnt_d      = enter_count ? '0 : (tick ? cnt_q + NUM_LED'(1) : cnt_q);
    sel_d      = sel_q;
    if (press[1]) sel_d = (sel_q == SELW'(NUM_RGB - 1)) ? '0 : sel_q + SELW'(1);
    bri_d = bri_q;
    if (press[2] && !press[3]) begin
      bri_d[sel_q] = (bri_q[sel_q] > BRI_MAX - BRI_STEP) ? BRI_MAX : bri_q[sel_q] + BRI_STEP;
    end else if (press[3] && !press[2]) begin
      bri_d[sel_q] = (bri_q[sel_q] < BRI_STEP) ? '0 : bri_q[sel_q] - BRI_STEP;
    end
  end

  // Triangle level while breathing, full scale otherwise; duty scales brightness by lvl+1.
  always_comb begin
    lvl  = '1;
    prod = '0;
    if (in_breathe) lvl = phase_q[PWM_BITS] ? ~phase_q[PWM_BITS-1:0] : phase_q[PWM_BITS-1:0];
    for (int k = 0; k < NUM_RGB; k++) begin
      prod        = (PW'(lvl) + PW'(1)) * PW'(bri_q[k]);
      duty_lin[k] = PWM_BITS'(prod >> PWM_BITS);
    end
  end

`ifdef ARTY_S7_PWM_GAMMA_EN
  localparam int SQW = 2 * PWM_BITS;
  logic [PWM_BITS-1:0] duty_q [NUM_RGB];
  logic [PWM_BITS-1:0] duty_d [NUM_RGB];
  logic [SQW-1:0]      sq;

  // Square-law gamma on the linear duty, one pipeline stage.
  always_comb begin
    sq = '0;
    for (int k = 0; k < NUM_RGB; k++) begin
      sq        = SQW'(duty_lin[k]) * SQW'(duty_lin[k]);
      duty_d[k] = PWM_BITS'(sq >> PWM_BITS);
    end
  end

  // Gamma pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_RGB; k++) duty_q[k] <= '0;
    end else begin
      duty_q <= duty_d;
    end
  end

  assign duty = duty_q;
`else
  assign duty = duty_lin;
`endif

  // Output mux and colour-gated PWM compare.
  always_comb begin
    led_d = in_count ? cnt_q : sw_s2_q;
    for (int k = 0; k < NUM_RGB; k++) begin
      r_d[k] = sw_s2_q[0] && (pwm_cnt_q < duty[k]);
      g_d[k] = sw_s2_q[1] && (pwm_cnt_q < duty[k]);
      b_d[k] = sw_s2_q[2] && (pwm_cnt_q < duty[k]);
    end
  end

  // Datapath state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      led_q      <= '0;
      cnt_q      <= '0;
      sel_q      <= '0;
      tick_cnt_q <= '0;
      br_cnt_q   <= '0;
      phase_q    <= '0;
      pwm_cnt_q  <= '0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
      for (int k = 0; k < NUM_RGB; k++) bri_q[k] <= BRI_RST;
    end else begin
      sw_s1_q    <= io.sw;
      sw_s2_q    <= sw_s1_q;
      led_q      <= led_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      tick_cnt_q <= tick_cnt_d;
      br_cnt_q   <= br_cnt_d;
      phase_q    <= phase_d;
      pwm_cnt_q  <= pwm_cnt_d;
      r_q        <= r_d;
      g_q        <= g_d;
      b_q        <= b_d;
      bri_q      <= bri_d;
    end
  end

  assign io.led   = led_q;
  assign io.led_r = r_q;
  assign io.led_g = g_q;
  assign io.led_b = b_q;
  assign io.mode  = mode_q;

endmodule

// File: tb/tb_arty_s7_rgb_ctrl.sv
// Self-checking bench for arty_s7_rgb_ctrl with small clock/step constants.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_arty_s7_rgb_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  // Expected state, tracked from the button rules.
  int m_mode, m_sel;
  int m_bri [2];
  int hr [2];
  int hg [2];
  int hb [2];

  arty_s7_rgb_ctrl_if #(.NUM_LED(4), .NUM_RGB(2)) io ();

  arty_s7_rgb_ctrl #(
    .CLK_FREQ(1000), .NUM_LED(4), .NUM_RGB(2),
    .PWM_BITS(8), .DEBOUNCE_MS(4), .STEP_HZ(100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int gam(input int b);
`ifdef ARTY_S7_PWM_GAMMA_EN
    return (b * b) >> 8;
`else
    return b;
`endif
  endfunction

  function automatic int sat(input int v);
    return (v > 255) ? 255 : ((v < 0) ? 0 : v);
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_sel  = 0;
    m_bri[0] = 64;
    m_bri[1] = 64;
  endtask

  task automatic press(input logic [3:0] m);
    io.btn = m;
    repeat (10) @(negedge clk);
    io.btn = 4'b0000;
    repeat (10) @(negedge clk);
    if (m[2] && !m[3]) m_bri[m_sel] = sat(m_bri[m_sel] + 32);
    if (m[3] && !m[2]) m_bri[m_sel] = sat(m_bri[m_sel] - 32);
    if (m[0]) m_mode = (m_mode + 1) % 3;
    if (m[1]) m_sel = (m_sel + 1) % 2;
  endtask

  task automatic measure();
    for (int k = 0; k < 2; k++) begin hr[k] = 0; hg[k] = 0; hb[k] = 0; end
    repeat (256) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        hr[k] += int'(io.led_r[k]);
        hg[k] += int'(io.led_g[k]);
        hb[k] += int'(io.led_b[k]);
      end
    end
  endtask

  task automatic check_duty(input string tag);
    repeat (6) @(negedge clk);
    measure();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_r%0d", tag, k), hr[k], io.sw[0] ? gam(m_bri[k]) : 0);
      check($sformatf("%s_g%0d", tag, k), hg[k], io.sw[1] ? gam(m_bri[k]) : 0);
      check($sformatf("%s_b%0d", tag, k), hb[k], io.sw[2] ? gam(m_bri[k]) : 0);
    end
  endtask

  initial begin
    logic [3:0] prev;
    logic [3:0] ops [4];
    int last_t, steps, bad, wrap, w1, w2;
    ops[0] = 4'b0010; ops[1] = 4'b0100; ops[2] = 4'b1000; ops[3] = 4'b1100;

    // Reset state.
    rst = 1'b1; io.sw = 4'b1010; io.btn = 4'b0000;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_led", io.led, 0);
    check("rst_r", io.led_r, 0);
    check("rst_g", io.led_g, 0);
    check("rst_b", io.led_b, 0);
    check("rst_mode", io.mode, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("sw_latency", io.led, 4'b1010);
    check_duty("rst_duty");

    // Short glitch is ignored; long hold gives one press.
    io.btn = 4'b0001; repeat (3) @(negedge clk);
    io.btn = 4'b0000; repeat (20) @(negedge clk);
    check("db_short", io.mode, 0);
    io.btn = 4'b0001; repeat (100) @(negedge clk);
    check("db_hold", io.mode, 1);
    io.btn = 4'b0000; repeat (20) @(negedge clk);
    check("db_release", io.mode, 1);
    m_mode = 1;

    // COUNT: +1 every 10 cycles, wraps, switches ignored.
    io.sw = 4'($urandom);
    prev = io.led; last_t = -1; steps = 0; bad = 0; wrap = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (io.led !== prev) begin
        if (io.led !== 4'(prev + 4'd1)) bad++;
        if (last_t >= 0 && (i - last_t) != 10) bad++;
        if (prev == 4'hF && io.led == 4'h0) wrap = 1;
        last_t = i;
        steps++;
        prev = io.led;
      end
    end
    check("cnt_bad_steps", bad, 0);
    check("cnt_nsteps_ge24", 32'(steps >= 24), 1);
    check("cnt_wrap", wrap, 1);
    press(4'b0001);
    check("mode_breathe", io.mode, m_mode);
    press(4'b0001);
    check("mode_sw", io.mode, m_mode);

    // Brightness up/down with saturation and gating.
    io.sw = 4'b0001;
    repeat (3) press(4'b0100);
    check_duty("bri160");
    repeat (5) press(4'b0100);
    check_duty("bri255");
    repeat (10) press(4'b1000);
    check_duty("bri0");
    press(4'b1100);
    check_duty("bri_both");
    press(4'b0010);
    press(4'b0100);
    check_duty("sel1");
    press(4'b0010);
    press(4'b0100);
    check_duty("sel_wrap");

    // Random button/switch mix against the model.
    for (int i = 0; i < 10; i++) begin
      io.sw = {1'($urandom), 2'($urandom), 1'b1};
      press(ops[$urandom_range(0, 3)]);
      check_duty($sformatf("rnd%0d", i));
    end

    // Breathe at full brightness: output periodic over 512 cycles and not a flat duty.
    io.sw = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      while (m_sel != k) press(4'b0010);
      repeat (8) press(4'b0100);
    end
    press(4'b0001);
    press(4'b0001);
    check("breathe_mode", io.mode, 2);
    w1 = 0; w2 = 0;
    repeat (512) begin @(negedge clk); w1 += int'(io.led_r[0]); end
    repeat (512) begin @(negedge clk); w2 += int'(io.led_r[0]); end
    check("breathe_periodic", w2, w1);
    check("breathe_not_flat", 32'(w1 != 2 * gam(255)), 1);
    repeat (37) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_mode", io.mode, 0);
    check("mid_rst_r", io.led_r, 0);
    check("mid_rst_g", io.led_g, 0);
    check("mid_rst_b", io.led_b, 0);
    rst = 1'b0;
    model_reset();

    // Brightness 128: linear 128, gamma 64.
    repeat (2) press(4'b0100);
    check_duty("bri128");

    // Button held across reset release gives a single press.
    rst = 1'b1; io.btn = 4'b0001;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("held_rst", io.mode, 1);
    io.btn = 4'b0000;
    repeat (20) @(negedge clk);
    check("held_rst_once", io.mode, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
